// File: rtl/systolic_tile.sv
// ROWS x COLS output-stationary systolic matrix multiplier: A streams right, B streams down.
// Optional build macro SYSTOLIC_TILE_SAT_EN makes the accumulators saturate instead of wrap.
module systolic_tile #(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int K_MAX      = 255
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [$clog2(K_MAX+1)-1:0]            k_len,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]            a_in,
    input  logic [COLS*DATA_WIDTH-1:0]            b_in,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [ACC_WIDTH-1:0]                  res_data,
    output logic [((ROWS>1)?$clog2(ROWS):1)-1:0]  res_row,
    output logic [((COLS>1)?$clog2(COLS):1)-1:0]  res_col,
    output logic                                  busy,
    output logic                                  done
);
    localparam int KW          = $clog2(K_MAX+1);
    localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW          = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int FW          = $clog2(ROWS+COLS) + 1;
    localparam int FLUSH_STEPS = ROWS + COLS - 2;
    localparam int DW          = DATA_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t          state_q;
    logic [KW-1:0]   k_len_q, k_cnt_q;
    logic [FW-1:0]   fl_cnt_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic            step, clr;
    int              res_sel;

    // Operand seen at the west/north input of every PE, and every accumulator.
    logic [ROWS*COLS*DW-1:0]        a_pe_flat, b_pe_flat;
    logic [ROWS*COLS*ACC_WIDTH-1:0] acc_flat;

    assign step = ((state_q == S_LOAD) && in_valid) || (state_q == S_FLUSH);
    assign clr  = (state_q == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_len_q  <= '0;
            k_cnt_q  <= '0;
            fl_cnt_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    k_len_q  <= k_len;
                    k_cnt_q  <= '0;
                    fl_cnt_q <= '0;
                    row_q    <= '0;
                    col_q    <= '0;
                    state_q  <= (k_len != '0) ? S_LOAD : S_DRAIN;
                end
                S_LOAD: if (in_valid) begin
                    k_cnt_q <= k_cnt_q + KW'(1);
                    if (k_cnt_q + KW'(1) == k_len_q)
                        state_q <= (FLUSH_STEPS == 0) ? S_DRAIN : S_FLUSH;
                end
                S_FLUSH: begin
                    fl_cnt_q <= fl_cnt_q + FW'(1);
                    if (fl_cnt_q == FW'(FLUSH_STEPS-1))
                        state_q <= S_DRAIN;
                end
                S_DRAIN: if (res_ready) begin
                    if (row_q == RW'(ROWS-1) && col_q == CW'(COLS-1)) begin
                        state_q <= S_DONE;
                    end else if (col_q == CW'(COLS-1)) begin
                        col_q <= '0;
                        row_q <= row_q + RW'(1);
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign res_valid = (state_q == S_DRAIN);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign res_row   = res_valid ? row_q : '0;
    assign res_col   = res_valid ? col_q : '0;

    always_comb begin
        res_sel  = int'(row_q) * COLS + int'(col_q);
        res_data = '0;
        if (state_q == S_DRAIN)
            res_data = acc_flat[res_sel*ACC_WIDTH +: ACC_WIDTH];
    end

    genvar gi, gj;

    // Row i of A is delayed i steps; zeros are injected outside LOAD.
    for (gi = 0; gi < ROWS; gi++) begin : g_askew
        logic [DW-1:0] src;
        assign src = (state_q == S_LOAD) ? a_in[gi*DW +: DW] : '0;
        if (gi == 0) begin : g_direct
            assign a_pe_flat[0 +: DW] = src;
        end else begin : g_dly
            logic [DW-1:0] dly_q [gi];
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    for (int d = 0; d < gi; d++) dly_q[d] <= '0;
                end else if (step) begin
                    dly_q[0] <= src;
                    for (int d = 1; d < gi; d++) dly_q[d] <= dly_q[d-1];
                end
            end
            assign a_pe_flat[(gi*COLS)*DW +: DW] = dly_q[gi-1];
        end
    end

    for (gi = 0; gi < COLS; gi++) begin : g_bskew
        logic [DW-1:0] src;
        assign src = (state_q == S_LOAD) ? b_in[gi*DW +: DW] : '0;
        if (gi == 0) begin : g_direct
            assign b_pe_flat[0 +: DW] = src;
        end else begin : g_dly
            logic [DW-1:0] dly_q [gi];
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    for (int d = 0; d < gi; d++) dly_q[d] <= '0;
                end else if (step) begin
                    dly_q[0] <= src;
                    for (int d = 1; d < gi; d++) dly_q[d] <= dly_q[d-1];
                end
            end
            assign b_pe_flat[gi*DW +: DW] = dly_q[gi-1];
        end
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_row
        for (gj = 0; gj < COLS; gj++) begin : g_pe
            logic signed [DW-1:0]        a_w, b_w;
            logic signed [2*DW-1:0]      prod;
            logic signed [ACC_WIDTH-1:0] addend, sum, acc_d, acc_q;

            assign a_w    = a_pe_flat[(gi*COLS+gj)*DW +: DW];
            assign b_w    = b_pe_flat[(gi*COLS+gj)*DW +: DW];
            assign prod   = a_w * b_w;
            assign addend = ACC_WIDTH'(prod);
            assign sum    = acc_q + addend;

`ifdef SYSTOLIC_TILE_SAT_EN
            localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            // Same-sign operands with a flipped result sign means overflow: clamp.
            always_comb begin
                acc_d = sum;
                if ((acc_q[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                    (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                    acc_d = acc_q[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
            end
`else
            assign acc_d = sum;
`endif

            always_ff @(posedge clk) begin
                if (rst || clr)  acc_q <= '0;
                else if (step)   acc_q <= acc_d;
            end
            assign acc_flat[(gi*COLS+gj)*ACC_WIDTH +: ACC_WIDTH] = acc_q;

            if (gj < COLS-1) begin : g_apass
                logic [DW-1:0] a_q;
                always_ff @(posedge clk) begin
                    if (rst || clr)  a_q <= '0;
                    else if (step)   a_q <= a_w;
                end
                assign a_pe_flat[(gi*COLS+gj+1)*DW +: DW] = a_q;
            end

            if (gi < ROWS-1) begin : g_bpass
                logic [DW-1:0] b_q;
                always_ff @(posedge clk) begin
                    if (rst || clr)  b_q <= '0;
                    else if (step)   b_q <= b_w;
                end
                assign b_pe_flat[((gi+1)*COLS+gj)*DW +: DW] = b_q;
            end
        end
    end
endmodule

// File: tb/tb_systolic_tile.sv
// Bench for systolic_tile: a 2x2 default tile checked against a plain matrix-multiply model,
// plus a 1x1 16-bit tile for accumulator overflow behaviour.
module tb_systolic_tile;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, in_valid, in_ready, res_valid, res_ready, busy, done;
    logic [7:0]  k_len;
    logic [15:0] a_in, b_in;
    logic [31:0] res_data;
    logic [0:0]  res_row, res_col;

    logic        s_start, s_in_valid, s_in_ready, s_res_valid, s_res_ready, s_busy, s_done;
    logic [7:0]  s_k_len, s_a_in, s_b_in;
    logic [15:0] s_res_data;
    logic [0:0]  s_res_row, s_res_col;

    systolic_tile dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_row(res_row), .res_col(res_col), .busy(busy), .done(done)
    );

    systolic_tile #(.ROWS(1), .COLS(1), .ACC_WIDTH(16)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .k_len(s_k_len),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .a_in(s_a_in), .b_in(s_b_in),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .res_data(s_res_data),
        .res_row(s_res_row), .res_col(s_res_col), .busy(s_busy), .done(s_done)
    );

    typedef struct { int row; int col; int val; } res_t;
    res_t exp_q[$];
    int   got_q[$];
    int   A[2][8];
    int   B[8][2];
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    bit   stall_seen = 0;
    logic [31:0] held_data;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result: plain C = A x B over the first k entries, row-major order.
    task automatic model_push(input int k);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                int s = 0;
                for (int kk = 0; kk < k; kk++) s += A[i][kk] * B[kk][j];
                exp_q.push_back('{i, j, s});
            end
    endtask

    task automatic load_job1();
        int av[6] = '{1, 2, 3, 4, 5, 6};
        int bv[6] = '{7, 1, 8, 0, 9, -1};
        for (int k = 0; k < 3; k++) begin
            A[0][k] = av[k];
            A[1][k] = av[3+k];
            B[k][0] = bv[2*k];
            B[k][1] = bv[2*k+1];
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},  int'(in_ready), 0);
        check({tag, "_res_valid"}, int'(res_valid), 0);
        check({tag, "_res_data"},  int'(res_data), 0);
        check({tag, "_res_row"},   int'(res_row), 0);
        check({tag, "_res_col"},   int'(res_col), 0);
        check({tag, "_busy"},      int'(busy), 0);
        check({tag, "_done"},      int'(done), 0);
    endtask

    task automatic check_got(input string tag, input int v0, input int v1, input int v2, input int v3);
        int lit[4];
        lit = '{v0, v1, v2, v3};
        check({tag, "_count"}, got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check({tag, "_word"}, got_q[i], lit[i]);
    endtask

    task automatic run_job(input int k, input bit gaps, input bit stalls,
                           input bit start_in_drain, input bit abort);
        int  beat = 0;
        int  cyc  = 0;
        int  d0;
        bit  acc;
        bit  restarted = 0;
        d0 = done_cnt;
        got_q.delete();
        if (!abort) model_push(k);
        start = 1'b1;
        k_len = 8'(k);
        tick();
        start = 1'b0;
        while (beat < k && cyc < 200) begin
            in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            a_in = {8'(A[1][beat]), 8'(A[0][beat])};
            b_in = {8'(B[beat][1]), 8'(B[beat][0])};
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) beat++;
            cyc++;
        end
        in_valid = 1'b0;
        check("feed_beats", beat, k);
        if (abort) begin
            check("flush_in_ready", int'(in_ready), 0);
            check("flush_busy", int'(busy), 1);
            rst = 1'b1;
            tick();
            check_idle_outputs("abort_rst");
            rst = 1'b0;
            repeat (6) tick();
            check("abort_done", done_cnt - d0, 0);
            check("abort_results", got_q.size(), 0);
            check("abort_busy", int'(busy), 0);
            return;
        end
        cyc = 0;
        while (done_cnt == d0 && cyc < 400) begin
            res_ready = stalls ? (cyc % 4 == 3) : 1'b1;
            in_valid  = 1'b1;
            a_in      = 16'($urandom);
            b_in      = 16'($urandom);
            start     = 1'b0;
            if (start_in_drain && res_valid && !restarted) begin
                start     = 1'b1;
                k_len     = 8'd3;
                restarted = 1;
            end
            tick();
            cyc++;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        check("done_pulse", done_cnt - d0, 1);
        check("results_left", exp_q.size(), 0);
        tick();
        check("idle_after_done", int'(busy), 0);
    endtask

    // Compare process: every accepted result word against the model, and stall stability.
    always @(negedge clk) begin
        if (rst) begin
            stall_seen = 0;
        end else begin
            if (done) begin
                done_cnt++;
                check("done_with_busy", int'(busy), 1);
            end
            if (stall_seen && res_valid)
                check("held_data", int'(res_data), int'(held_data));
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", int'(res_valid), 0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("res_row", int'(res_row), e.row);
                    check("res_col", int'(res_col), e.col);
                    check("res_data", $signed(res_data), e.val);
                    got_q.push_back($signed(res_data));
                end
            end
            stall_seen = res_valid && !res_ready;
            held_data  = res_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int sv;
        int s_exp;
        rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; res_ready = 1'b0;
        a_in = '0; b_in = '0;
        s_start = 1'b0; s_k_len = '0; s_in_valid = 1'b0; s_res_ready = 1'b1;
        s_a_in = '0; s_b_in = '0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        load_job1();
        run_job(3, 0, 0, 0, 0);
        check_got("job_basic", 50, -2, 122, -2);

        run_job(3, 1, 1, 0, 0);
        check_got("job_stall", 50, -2, 122, -2);

        run_job(3, 0, 1, 1, 0);
        check_got("job_start_in_drain", 50, -2, 122, -2);

        run_job(2, 0, 0, 0, 1);

        A[0][0] = 1; A[1][0] = 1; B[0][0] = 2; B[0][1] = 3;
        run_job(1, 0, 0, 0, 0);
        check_got("job_after_abort", 2, 3, 2, 3);

        run_job(0, 0, 0, 0, 0);
        check_got("job_k0", 0, 0, 0, 0);

        for (int k = 0; k < 5; k++) begin
            A[0][k] = int'($urandom_range(0, 255)) - 128;
            A[1][k] = int'($urandom_range(0, 255)) - 128;
            B[k][0] = int'($urandom_range(0, 255)) - 128;
            B[k][1] = int'($urandom_range(0, 255)) - 128;
        end
        A[0][0] = -128; B[0][0] = -128;
        run_job(5, 1, 0, 0, 0);

`ifdef SYSTOLIC_TILE_SAT_EN
        s_exp = 32767;
`else
        s_exp = -17149;
`endif
        s_start = 1'b1; s_k_len = 8'd3;
        tick();
        s_start = 1'b0; s_in_valid = 1'b1; s_a_in = 8'd127; s_b_in = 8'd127;
        cyc = 0;
        while (!s_res_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        s_in_valid = 1'b0;
        check("sat_res_valid", int'(s_res_valid), 1);
        sv = $signed(s_res_data);
        check("sat_res_data", sv, s_exp);
        tick();
        check("sat_done", int'(s_done), 1);
        tick();
        check("sat_idle", int'(s_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/systolic_tile.md
SYSTOLIC_TILE -- requirements
Module: systolic_tile

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ROWS  2  PE rows; output-matrix rows (>=1)
  COLS  2  PE columns; output-matrix columns (>=1)
  DATA_WIDTH  8  signed operand width
  ACC_WIDTH  32  signed accumulator/result width
  K_MAX  255  maximum reduction length; k_len width = $clog2(K_MAX+1)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, all state on rising edge
  rst  in  1  synchronous, active-high reset
  start  in  1  begin job; sampled only in IDLE
  k_len  in  $clog2(K_MAX+1)  reduction length, captured with start
  in_valid  in  1  operand beat present
  in_ready  out  1  tile accepts beat
  a_in  in  ROWS*DATA_WIDTH  A column k; slice i = A[i][k]
  b_in  in  COLS*DATA_WIDTH  B row k; slice j = B[k][j]
  res_valid  out  1  result word present
  res_ready  in  1  consumer accepts result
  res_data  out  ACC_WIDTH  C[res_row][res_col]
  res_row  out  $clog2(ROWS)  (min 1 bit) result row index
  res_col  out  $clog2(COLS)  (min 1 bit) result column index
  busy  out  1  high in any state except IDLE
  done  out  1  one-cycle pulse at job end

Function
REQ-003 SHALL compute C = A x B (ROWS x k_len times k_len x COLS), signed, using a ROWS x COLS systolic grid: A flows right, B flows down, products accumulate in place.
REQ-004 FSM states SHALL be IDLE, LOAD, FLUSH, DRAIN, DONE.
REQ-005 IDLE: start=1 -> capture k_len, clear all accumulators; go LOAD if k_len>0, else DRAIN (all results 0).
REQ-006 LOAD: in_ready=1; beat accepted when in_valid&in_ready; array advances one step only on an accepted beat; no advance on idle cycles (full freeze).
REQ-007 Input skew: row i of A and column j of B delayed i and j steps; beat k product SHALL accumulate into PE(i,j) at step k+i+j.
REQ-008 After k_len-th beat -> FLUSH; FLUSH SHALL run exactly ROWS+COLS-2 steps, one per cycle, injecting zeros, in_ready=0; ROWS=COLS=1 skips FLUSH.
REQ-009 DRAIN: res_valid=1, results in row-major order (0,0),(0,1)...(ROWS-1,COLS-1); index advances only on res_valid&res_ready; outputs stable while res_ready=0.
REQ-010 After final result handshake -> DONE for one cycle (done=1, busy=1), then IDLE.
REQ-011 start outside IDLE SHALL be ignored; in_valid outside LOAD SHALL be ignored.
REQ-012 Products are full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH before add.

Reset
REQ-013 rst=1 at a clock edge SHALL force IDLE from any state, clear accumulators, skew registers, counters, result index.
REQ-014 During/after reset: in_ready=0, res_valid=0, res_data=0, res_row=0, res_col=0, busy=0, done=0.
REQ-015 Reset mid-job SHALL abandon the job; no done pulse, no result emitted.

Configuration
REQ-016 Macro SYSTOLIC_TILE_SAT_EN defined: accumulation saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], sticky at the limit against same-sign adds.
REQ-017 Macro undefined: accumulation wraps modulo 2^ACC_WIDTH; no saturation logic synthesised.

Verification
REQ-018 Default params, k_len=3, A=[[1,2,3],[4,5,6]], B cols [7,8,9],[1,0,-1], in_valid always 1 -> results in order 50,-2,122,-2, then done pulse.
REQ-019 Same job with in_valid low on alternate cycles, res_ready low 3 cycles per word -> identical values and order; res_data held while stalled.
REQ-020 ACC_WIDTH=16, ROWS=COLS=1, k_len=3, a=b=127 each beat -> 32767 with SYSTOLIC_TILE_SAT_EN, -17149 without.
REQ-021 rst pulsed during FLUSH, then new job k_len=1 a={1,1} b={2,3} -> clean 2,3,2,3; no stale data.
REQ-022 start asserted in DRAIN and k_len=0 job from IDLE -> first ignored; second yields four zeros then done.
